// File: rtl/instr_encoder_pkg.sv
// Shared encoder definitions: instruction format codes, opcodes, controller states and the encode helper.
// Imported by instr_encoder and by the control unit.
package instr_encoder_pkg;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } enc_state_e;

   typedef struct packed {
      logic        legal;
      logic [31:0] word;
   } enc_result_t;

   // Branch and jump offsets must be even; shift-immediates carry funct7b5 in the upper bits.
   function automatic enc_result_t encode_instr(
      input fmt_e        fmt,
      input logic [6:0]  op,
      input logic [2:0]  funct3,
      input logic        funct7b5,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [31:0] imm
   );
      enc_result_t res;
      res.legal = 1'b0;
      res.word  = 32'd0;
      case (fmt)
         FMT_R: begin
            res.legal = (op == OP_REG);
            res.word  = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, op};
         end
         FMT_I: begin
            res.legal = (op == OP_LOAD) || (op == OP_IMM) || (op == OP_JALR);
            if ((op == OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101))) begin
               res.word = {1'b0, funct7b5, 5'b00000, imm[4:0], rs1, funct3, rd, op};
            end else begin
               res.word = {imm[11:0], rs1, funct3, rd, op};
            end
         end
         FMT_S: begin
            res.legal = (op == OP_STORE);
            res.word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
         end
         FMT_B: begin
            res.legal = (op == OP_BRANCH) && !imm[0];
            res.word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
         end
         FMT_U: begin
            res.legal = (op == OP_LUI) || (op == OP_AUIPC);
            res.word  = {imm[31:12], rd, op};
         end
         FMT_J: begin
            res.legal = (op == OP_JAL) && !imm[0];
            res.word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
         default: begin
            res.legal = 1'b0;
            res.word  = 32'd0;
         end
      endcase
      return res;
   endfunction

endpackage

// File: rtl/instr_encoder_sync_fifo.sv
// Small synchronous FIFO with registered storage; head is visible whenever not empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      level_r;
   logic             push_s;
   logic             pop_s;

   assign full   = (level_r == (AW+1)'(DEPTH));
   assign empty  = (level_r == (AW+1)'(0));
   assign push_s = push & ~full;
   assign pop_s  = pop & ~empty;
   assign head   = mem_r[rd_ptr_r];
   assign level  = level_r;

   // Storage and pointers; a push is refused while full even if a pop frees a slot this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         level_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + (AW+1)'(1);
            2'b01:   level_r <= level_r - (AW+1)'(1);
            default: level_r <= level_r;
         endcase
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes instruction requests into 32-bit words and streams them into
// instruction memory at consecutive word addresses through a small FIFO.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] base_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_last,
   input  logic [2:0]  fmt,
   input  logic [6:0]  op,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic        imem_we,
   input  logic        imem_ready,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic [15:0] word_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   enc_state_e       state_r;
   enc_state_e       state_next_s;
   logic             busy_r;
   logic             done_r;
   logic             err_r;
   logic             req_ready_r;
   logic [31:0]      addr_r;
   logic [15:0]      count_r;
   logic             full_s;
   logic             empty_s;
   logic [CNT_W-1:0] fill_s;
   logic [CNT_W-1:0] fill_next_s;
   logic [31:0]      head_s;
   enc_result_t      enc_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;

   assign enc_s    = encode_instr(fmt_e'(fmt), op, funct3, funct7b5, rd, rs1, rs2, imm);
   assign accept_s = req_valid & req_ready_r;
   assign push_s   = accept_s & enc_s.legal & ~full_s;
   assign pop_s    = ~empty_s & imem_ready;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data (enc_s.word),
      .pop       (pop_s),
      .head      (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .level     (fill_s)
   );

   // Next-state and next FIFO fill, used to register the handshake and status outputs.
   always_comb begin
      state_next_s = state_r;
      fill_next_s  = fill_s + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
      case (state_r)
         ST_IDLE: begin
            if (start) state_next_s = ST_RUN;
            else       state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            if (accept_s && req_last) state_next_s = ST_DRAIN;
            else                      state_next_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (empty_s) state_next_s = ST_DONE;
            else         state_next_s = ST_DRAIN;
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Controller state, registered outputs, address/count tracking and the sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         req_ready_r <= 1'b0;
         addr_r      <= 32'd0;
         count_r     <= 16'd0;
      end else begin
         state_r     <= state_next_s;
         busy_r      <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
         done_r      <= (state_next_s == ST_DONE);
         req_ready_r <= (state_next_s == ST_RUN) && (fill_next_s != CNT_W'(FIFO_DEPTH));
         if ((state_r == ST_IDLE) && start) begin
            addr_r  <= base_addr;
            count_r <= 16'd0;
            err_r   <= 1'b0;
         end else begin
            if (accept_s && !enc_s.legal) begin
               err_r <= 1'b1;
            end
            if (pop_s) begin
               addr_r <= addr_r + 32'd4;
               if (count_r != 16'hFFFF) begin
                  count_r <= count_r + 16'd1;
               end
            end
         end
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;
   assign req_ready  = req_ready_r;
   assign imem_we    = ~empty_s;
   assign imem_addr  = addr_r;
   assign imem_wdata = head_s;
   assign word_count = count_r;

endmodule
